alu_rs: RTL and testbench

- ALU reservation station; the initiating end of the RS→ALU dispatch interface.
- Accepts decoded integer, branch, jump, lui and auipc instructions from the issue stage. Holds them until both operands are ready, snooping the ALU and LSB result broadcasts for operand values.
- Dispatches at most one ready instruction per cycle to the ALU as a one-cycle alu_en pulse with its full operand bundle.

---
 rtl/alu_rs_pkg.sv | 30 +++
 rtl/alu_rs_if.sv | 29 ++
 rtl/rs_prio_enc.sv | 22 ++
 rtl/alu_rs.sv | 167 ++++++++++++++++
 tb/tb_alu_rs.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, opcodes and entry payload type for the ALU
// reservation station.
package alu_rs_pkg;

  localparam int OP_WID      = 7;
  localparam int FUNCT3_WID  = 3;
  localparam int ROB_POS_WID = 4;
  localparam int RS_SIZE     = 16;

  localparam logic [OP_WID-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_WID-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OP_WID-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_WID-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_WID-1:0] OP_BR    = 7'b1100011;
  localparam logic [OP_WID-1:0] OP_ARI   = 7'b0010011;
  localparam logic [OP_WID-1:0] OP_ARR   = 7'b0110011;

  typedef struct packed {
    logic [OP_WID-1:0]     opcode;
    logic [FUNCT3_WID-1:0] funct3;
    logic                  funct7;
    logic [31:0]           imm;
    logic [31:0]           pc;
  } rs_ctl_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// RS -> ALU dispatch bundle; the RS drives the master side
// with a one-cycle alu_en pulse.
interface alu_rs_if #(
  parameter int ROB_POS_W = alu_rs_pkg::ROB_POS_WID
) ();

  logic                 alu_en;
  logic [6:0]           alu_opcode;
  logic [2:0]           alu_funct3;
  logic                 alu_funct7;
  logic [31:0]          alu_val1;
  logic [31:0]          alu_val2;
  logic [31:0]          alu_imm;
  logic [31:0]          alu_pc;
  logic [ROB_POS_W-1:0] alu_rob_pos;

  modport master (
    output alu_en, alu_opcode, alu_funct3,
    output alu_funct7, alu_val1, alu_val2,
    output alu_imm, alu_pc, alu_rob_pos
  );

  modport slave (
    input alu_en, alu_opcode, alu_funct3,
    input alu_funct7, alu_val1, alu_val2,
    input alu_imm, alu_pc, alu_rob_pos
  );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: found flag plus index
// of the lowest set request bit.
module rs_prio_enc #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  assign o_found = |i_req;

  // Scan downwards so the lowest set bit is written last.
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) o_idx = IW'(k);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ops until both operands
// are known, then dispatches the lowest ready entry to the ALU.
module alu_rs #(
  parameter int RS_SIZE   = alu_rs_pkg::RS_SIZE,
  parameter int ROB_POS_W = alu_rs_pkg::ROB_POS_WID
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_valid,
  input  logic [6:0]           issue_opcode,
  input  logic [2:0]           issue_funct3,
  input  logic                 issue_funct7,
  input  logic                 issue_q1_rdy,
  input  logic [31:0]          issue_v1,
  input  logic [ROB_POS_W-1:0] issue_q1,
  input  logic                 issue_q2_rdy,
  input  logic [31:0]          issue_v2,
  input  logic [ROB_POS_W-1:0] issue_q2,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_pc,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic                 rs_full,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]          lsb_result_val,
  alu_rs_if.master             alu
);

  import alu_rs_pkg::*;

  localparam int IW = idx_w(RS_SIZE);

  logic [RS_SIZE-1:0]   r_valid;
  logic [RS_SIZE-1:0]   r_q1_rdy;
  logic [RS_SIZE-1:0]   r_q2_rdy;
  logic [31:0]          r_v1  [RS_SIZE];
  logic [31:0]          r_v2  [RS_SIZE];
  logic [ROB_POS_W-1:0] r_q1  [RS_SIZE];
  logic [ROB_POS_W-1:0] r_q2  [RS_SIZE];
  logic [ROB_POS_W-1:0] r_rob [RS_SIZE];
  rs_ctl_t              r_ctl [RS_SIZE];

  logic                 r_en;
  rs_ctl_t              r_out_ctl;
  logic [31:0]          r_out_v1;
  logic [31:0]          r_out_v2;
  logic [ROB_POS_W-1:0] r_out_rob;

  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_found;
  logic [IW-1:0]      w_free_idx;
  logic               w_sel_found;
  logic [IW-1:0]      w_sel_idx;
  logic               w_alloc;
  rs_ctl_t            w_iss_ctl;

  assign w_ready = r_valid & r_q1_rdy & r_q2_rdy;
  assign rs_full = &r_valid;
  assign w_alloc = issue_valid & ~rs_full;

  assign w_iss_ctl = '{
    opcode: issue_opcode,
    funct3: issue_funct3,
    funct7: issue_funct7,
    imm:    issue_imm,
    pc:     issue_pc
  };

  rs_prio_enc #(.N(RS_SIZE), .IW(IW)) u_free (
    .i_req   (~r_valid),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .IW(IW)) u_sel (
    .i_req   (w_ready),
    .o_found (w_sel_found),
    .o_idx   (w_sel_idx)
  );

  // Operand snoop shared by issue forwarding and wakeup;
  // ALU wins if both buses carry the same tag.
  function automatic logic [32:0] fwd(
    input logic                 rdy_in,
    input logic [31:0]          v,
    input logic [ROB_POS_W-1:0] q
  );
    if (rdy_in)
      return {1'b1, v};
    if (alu_result && alu_result_rob_pos == q)
      return {1'b1, alu_result_val};
    if (lsb_result && lsb_result_rob_pos == q)
      return {1'b1, lsb_result_val};
    return {1'b0, v};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_q1_rdy  <= '0;
      r_q2_rdy  <= '0;
      r_en      <= 1'b0;
      r_out_ctl <= '0;
      r_out_v1  <= '0;
      r_out_v2  <= '0;
      r_out_rob <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_v1[i]  <= '0;
        r_v2[i]  <= '0;
        r_q1[i]  <= '0;
        r_q2[i]  <= '0;
        r_rob[i] <= '0;
        r_ctl[i] <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        r_valid <= '0;
        r_en    <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_valid[i]) begin
            {r_q1_rdy[i], r_v1[i]} <=
              fwd(r_q1_rdy[i], r_v1[i], r_q1[i]);
            {r_q2_rdy[i], r_v2[i]} <=
              fwd(r_q2_rdy[i], r_v2[i], r_q2[i]);
          end
        end
        r_en <= w_sel_found;
        if (w_sel_found) begin
          r_out_ctl          <= r_ctl[w_sel_idx];
          r_out_v1           <= r_v1[w_sel_idx];
          r_out_v2           <= r_v2[w_sel_idx];
          r_out_rob          <= r_rob[w_sel_idx];
          r_valid[w_sel_idx] <= 1'b0;
        end
        // Free slot is never the selected one: select needs valid.
        if (w_alloc && w_free_found) begin
          r_valid[w_free_idx] <= 1'b1;
          r_ctl[w_free_idx]   <= w_iss_ctl;
          r_rob[w_free_idx]   <= issue_rob_pos;
          r_q1[w_free_idx]    <= issue_q1;
          r_q2[w_free_idx]    <= issue_q2;
          {r_q1_rdy[w_free_idx], r_v1[w_free_idx]} <=
            fwd(issue_q1_rdy, issue_v1, issue_q1);
          {r_q2_rdy[w_free_idx], r_v2[w_free_idx]} <=
            fwd(issue_q2_rdy, issue_v2, issue_q2);
        end
      end
    end
  end

  assign alu.alu_en      = r_en;
  assign alu.alu_opcode  = r_out_ctl.opcode;
  assign alu.alu_funct3  = r_out_ctl.funct3;
  assign alu.alu_funct7  = r_out_ctl.funct7;
  assign alu.alu_val1    = r_out_v1;
  assign alu.alu_val2    = r_out_v2;
  assign alu.alu_imm     = r_out_ctl.imm;
  assign alu.alu_pc      = r_out_ctl.pc;
  assign alu.alu_rob_pos = r_out_rob;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: vector table for single-op
// dispatch plus hand sequences for wakeup, fill, flush, stall.
module tb_alu_rs;

  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        rollback;
  logic        issue_valid;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic        issue_q1_rdy;
  logic [31:0] issue_v1;
  logic [3:0]  issue_q1;
  logic        issue_q2_rdy;
  logic [31:0] issue_v2;
  logic [3:0]  issue_q2;
  logic [31:0] issue_imm;
  logic [31:0] issue_pc;
  logic [3:0]  issue_rob_pos;
  logic        rs_full;
  logic        alu_result;
  logic [3:0]  alu_result_rob_pos;
  logic [31:0] alu_result_val;
  logic        lsb_result;
  logic [3:0]  lsb_result_rob_pos;
  logic [31:0] lsb_result_val;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_rs_if #(.ROB_POS_W(4)) alu ();

  alu_rs #(.RS_SIZE(16), .ROB_POS_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rdy                (rdy),
    .rollback           (rollback),
    .issue_valid        (issue_valid),
    .issue_opcode       (issue_opcode),
    .issue_funct3       (issue_funct3),
    .issue_funct7       (issue_funct7),
    .issue_q1_rdy       (issue_q1_rdy),
    .issue_v1           (issue_v1),
    .issue_q1           (issue_q1),
    .issue_q2_rdy       (issue_q2_rdy),
    .issue_v2           (issue_v2),
    .issue_q2           (issue_q2),
    .issue_imm          (issue_imm),
    .issue_pc           (issue_pc),
    .issue_rob_pos      (issue_rob_pos),
    .rs_full            (rs_full),
    .alu_result         (alu_result),
    .alu_result_rob_pos (alu_result_rob_pos),
    .alu_result_val     (alu_result_val),
    .lsb_result         (lsb_result),
    .lsb_result_rob_pos (lsb_result_rob_pos),
    .lsb_result_val     (lsb_result_val),
    .alu                (alu)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic [10:0] e_code;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [31:0] e_imm;
    logic [31:0] e_pc;
    logic [3:0]  e_rob;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    issue_valid = 1'b0;
    alu_result  = 1'b0;
    lsb_result  = 1'b0;
    rollback    = 1'b0;
  endtask

  task automatic issue(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        f7,
    input logic        r1,
    input logic [31:0] v1,
    input logic [3:0]  q1,
    input logic        r2,
    input logic [31:0] v2,
    input logic [3:0]  q2,
    input logic [31:0] imm,
    input logic [31:0] pc,
    input logic [3:0]  rob
  );
    issue_valid   = 1'b1;
    issue_opcode  = op;
    issue_funct3  = f3;
    issue_funct7  = f7;
    issue_q1_rdy  = r1;
    issue_v1      = v1;
    issue_q1      = q1;
    issue_q2_rdy  = r2;
    issue_v2      = v2;
    issue_q2      = q2;
    issue_imm     = imm;
    issue_pc      = pc;
    issue_rob_pos = rob;
  endtask

  task automatic bcast_alu(input logic [3:0] t, input logic [31:0] v);
    alu_result         = 1'b1;
    alu_result_rob_pos = t;
    alu_result_val     = v;
  endtask

  task automatic bcast_lsb(input logic [3:0] t, input logic [31:0] v);
    lsb_result         = 1'b1;
    lsb_result_rob_pos = t;
    lsb_result_val     = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{OP_ARR, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0,
                32'h100, 4'd3,
                {7'b0110011, 3'd0, 1'b0}, 32'd5, 32'd7,
                32'd0, 32'h100, 4'd3};
    vecs[1] = '{OP_ARI, 3'd7, 1'b0, 32'hFFFF_0000, 32'h0000_00FF,
                32'h0000_00FF, 32'h104, 4'd5,
                {7'b0010011, 3'd7, 1'b0}, 32'hFFFF_0000,
                32'h0000_00FF, 32'h0000_00FF, 32'h104, 4'd5};
    vecs[2] = '{OP_BR, 3'd1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                32'hFFFF_FFF0, 32'h200, 4'd15,
                {7'b1100011, 3'd1, 1'b0}, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 32'hFFFF_FFF0, 32'h200, 4'd15};
    vecs[3] = '{OP_ARR, 3'd0, 1'b1, 32'h8000_0000, 32'd1,
                32'd0, 32'h0, 4'd0,
                {7'b0110011, 3'd0, 1'b1}, 32'h8000_0000,
                32'd1, 32'd0, 32'h0, 4'd0};

    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
    issue(7'd0, 3'd0, 1'b0, 1'b0, 32'd0, 4'd0,
          1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);
    issue_valid = 1'b0;
    alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_en",   alu.alu_en, 32'd0);
    chk("rst_full", rs_full, 32'd0);
    chk("rst_val1", alu.alu_val1, 32'd0);
    chk("rst_rob",  alu.alu_rob_pos, 32'd0);

    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b1, vecs[i].v1,
            4'd0, 1'b1, vecs[i].v2, 4'd0, vecs[i].imm,
            vecs[i].pc, vecs[i].rob);
      step();
      chk($sformatf("v%0d_en_alloc", i), alu.alu_en, 32'd0);
      step();
      chk($sformatf("v%0d_en", i), alu.alu_en, 32'd1);
      chk($sformatf("v%0d_code", i),
          {alu.alu_opcode, alu.alu_funct3, alu.alu_funct7},
          vecs[i].e_code);
      chk($sformatf("v%0d_val1", i), alu.alu_val1, vecs[i].e_v1);
      chk($sformatf("v%0d_val2", i), alu.alu_val2, vecs[i].e_v2);
      chk($sformatf("v%0d_imm", i),  alu.alu_imm,  vecs[i].e_imm);
      chk($sformatf("v%0d_pc", i),   alu.alu_pc,   vecs[i].e_pc);
      chk($sformatf("v%0d_rob", i),  alu.alu_rob_pos, vecs[i].e_rob);
      step();
      chk($sformatf("v%0d_en_off", i), alu.alu_en, 32'd0);
    end

    // Wakeup of operand 1 from the ALU bus
    issue(OP_ARR, 3'd0, 1'b0, 1'b0, 32'd0, 4'd2,
          1'b1, 32'd3, 4'd0, 32'd0, 32'h300, 4'd8);
    step();
    step();
    chk("wk_wait", alu.alu_en, 32'd0);
    bcast_alu(4'd2, 32'h10);
    step();
    chk("wk_edge", alu.alu_en, 32'd0);
    step();
    chk("wk_en",   alu.alu_en, 32'd1);
    chk("wk_val1", alu.alu_val1, 32'h10);
    chk("wk_val2", alu.alu_val2, 32'd3);
    chk("wk_rob",  alu.alu_rob_pos, 32'd8);
    step();

    // Issue-cycle forward of operand 2 from the LSB bus
    issue(OP_ARR, 3'd4, 1'b0, 1'b1, 32'd1, 4'd0,
          1'b0, 32'd0, 4'd6, 32'd0, 32'h400, 4'd9);
    bcast_lsb(4'd6, 32'hABCD);
    step();
    chk("fw_alloc", alu.alu_en, 32'd0);
    step();
    chk("fw_en",   alu.alu_en, 32'd1);
    chk("fw_val2", alu.alu_val2, 32'hABCD);
    chk("fw_rob",  alu.alu_rob_pos, 32'd9);
    step();

    // Fill all entries; entry i waits on tag i
    for (int i = 0; i < 16; i++) begin
      issue(OP_ARR, 3'd0, 1'b0, 1'b0, 32'd0, 4'(i),
            1'b1, 32'(i), 4'd0, 32'd0, 32'(i * 4), 4'(i));
      step();
    end
    chk("fill_full", rs_full, 32'd1);
    chk("fill_en",   alu.alu_en, 32'd0);
    issue(OP_ARR, 3'd0, 1'b0, 1'b1, 32'h777, 4'd0,
          1'b1, 32'd1, 4'd0, 32'd0, 32'h500, 4'd14);
    step();
    chk("drop_full", rs_full, 32'd1);
    chk("drop_en",   alu.alu_en, 32'd0);
    bcast_alu(4'd4, 32'h44);
    bcast_lsb(4'd9, 32'h99);
    step();
    chk("wake2_en", alu.alu_en, 32'd0);
    step();
    chk("d4_en",   alu.alu_en, 32'd1);
    chk("d4_rob",  alu.alu_rob_pos, 32'd4);
    chk("d4_val1", alu.alu_val1, 32'h44);
    chk("d4_pc",   alu.alu_pc, 32'd16);
    chk("d4_full", rs_full, 32'd0);
    step();
    chk("d9_en",   alu.alu_en, 32'd1);
    chk("d9_rob",  alu.alu_rob_pos, 32'd9);
    chk("d9_val1", alu.alu_val1, 32'h99);
    chk("d9_val2", alu.alu_val2, 32'd9);
    step();
    chk("d_idle", alu.alu_en, 32'd0);

    // Flush with 14 pending plus an ignored issue
    rollback = 1'b1;
    issue(OP_ARR, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0,
          1'b1, 32'd1, 4'd0, 32'd0, 32'h600, 4'd1);
    step();
    chk("rb_en",   alu.alu_en, 32'd0);
    chk("rb_full", rs_full, 32'd0);
    for (int t = 0; t < 16; t++) begin
      bcast_alu(4'(t), 32'h55);
      step();
      chk($sformatf("rb_quiet%0d", t), alu.alu_en, 32'd0);
    end
    step();
    chk("rb_quiet_end", alu.alu_en, 32'd0);

    // Stall with rdy low, then async reset mid-dispatch
    issue(OP_LUI, 3'd0, 1'b0, 1'b1, 32'h1234, 4'd0,
          1'b1, 32'd0, 4'd0, 32'h1000, 32'h700, 4'd11);
    step();
    chk("st_alloc", alu.alu_en, 32'd0);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("st_hold%0d", k), alu.alu_en, 32'd0);
    end
    rdy = 1'b1;
    step();
    chk("st_en",   alu.alu_en, 32'd1);
    chk("st_rob",  alu.alu_rob_pos, 32'd11);
    chk("st_val1", alu.alu_val1, 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_en",   alu.alu_en, 32'd0);
    chk("ar_rob",  alu.alu_rob_pos, 32'd0);
    chk("ar_full", rs_full, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
